// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks a 5-input function through all 32 input vectors,
// captures its truth table, and compares it against a reference mask.
module truth_table_sweeper #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] expected_mask,
    input  logic        func_in,
    output logic [4:0]  vec_out,
    output logic        busy,
    output logic        done,
    output logic [31:0] minterm_mask,
    output logic [5:0]  ones_count,
    output logic        mismatch
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;
    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [4:0]  vec_q, vec_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mask_q, mask_d;
    logic [5:0]  ones_q, ones_d;
    logic        mis_q, mis_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        ones_d  = ones_q;
        mis_d   = mis_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    idx_d   = 5'd0;
                    vec_d   = 5'd0;
                    cnt_d   = SETTLE_CNT;
                    mask_d  = 32'd0;
                    ones_d  = 6'd0;
                    mis_d   = 1'b0;
                end
            end
            ST_SETTLE: begin
                vec_d = idx_q;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                mask_d[idx_q] = func_in;
                ones_d = ones_q + {5'd0, func_in};
                if (idx_q == 5'd31) begin
                    // mismatch is registered together with the final mask so it is valid alongside done
                    state_d = ST_DONE;
                    mis_d   = mask_d != expected_mask;
                end else begin
                    state_d = ST_SETTLE;
                    idx_d   = idx_q + 5'd1;
                    vec_d   = idx_q + 5'd1;
                    cnt_d   = SETTLE_CNT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
        done_d = state_d == ST_DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 5'd0;
            vec_q   <= 5'd0;
            cnt_q   <= 4'd0;
            mask_q  <= 32'd0;
            ones_q  <= 6'd0;
            mis_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            ones_q  <= ones_d;
            mis_q   <= mis_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign vec_out      = vec_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign minterm_mask = mask_q;
    assign ones_count   = ones_q;
    assign mismatch     = mis_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed checks of two sweeper instances (SETTLE=1 and SETTLE=3).
module tb_truth_table_sweeper;
    logic        clk = 1'b0, rst_n = 1'b1, start1 = 1'b0, start3 = 1'b0;
    logic [31:0] exp1 = 32'd0, exp3 = 32'd0;
    int          m1 = 0, m3 = 0;
    logic [4:0]  vec1, vec3;
    logic        busy1, busy3, done1, done3, mis1, mis3, f1, f3;
    logic [31:0] mask1, mask3;
    logic [5:0]  ones1, ones3;
    int          checks = 0, errors = 0;
    int          run3 = 0, bad3 = 0, chg3 = 0;
    logic [4:0]  prev3 = 5'd0;
    always #5 clk = ~clk;
    // function under test: 0 = tied low, 1 = e (LSB), 2 = AND of all inputs
    assign f1 = (m1 == 0) ? 1'b0 : (m1 == 1) ? vec1[0] : &vec1;
    assign f3 = (m3 == 0) ? 1'b0 : (m3 == 1) ? vec3[0] : &vec3;
    truth_table_sweeper #(.SETTLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected_mask(exp1), .func_in(f1),
        .vec_out(vec1), .busy(busy1), .done(done1), .minterm_mask(mask1),
        .ones_count(ones1), .mismatch(mis1)
    );
    truth_table_sweeper #(.SETTLE(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .expected_mask(exp3), .func_in(f3),
        .vec_out(vec3), .busy(busy3), .done(done3), .minterm_mask(mask3),
        .ones_count(ones3), .mismatch(mis3)
    );
    // run-length monitor: every vector of the SETTLE=3 instance must be held exactly 4 cycles
    always @(negedge clk) begin
        if (!busy3) begin
            run3  <= 0;
            prev3 <= vec3;
        end else if (vec3 == prev3) begin
            run3 <= run3 + 1;
        end else begin
            if (run3 != 0) begin
                chg3 <= chg3 + 1;
                if (run3 != 4) bad3 <= bad3 + 1;
            end
            run3  <= 1;
            prev3 <= vec3;
        end
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // pulse start on one instance, optionally re-pulse at a given vector, count cycles to done
    task automatic sweep(input bit use3, input int pulse_vec, output int n);
        bit pulsed = 1'b0;
        n = 0;
        if (use3) start3 = 1'b1; else start1 = 1'b1;
        while (n < 400) begin
            @(negedge clk);
            n++;
            start1 = 1'b0;
            start3 = 1'b0;
            if (use3 ? done3 : done1) break;
            if (!use3 && pulse_vec >= 0 && !pulsed && busy1 && vec1 == 5'(pulse_vec)) begin
                start1 = 1'b1;
                pulsed = 1'b1;
            end
        end
    endtask
    initial begin
        int n, k, low, nd;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_vec", vec1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_mask", mask1, 0);
        chk("rst_ones", ones1, 0);
        chk("rst_mis", mis1, 0);
        @(negedge clk) rst_n = 1'b1;
        m1 = 0; exp1 = 32'd0;
        sweep(1'b0, -1, n);
        chk("zero_lat", n, 65);
        chk("zero_mask", mask1, 32'h0);
        chk("zero_ones", ones1, 0);
        chk("zero_mis", mis1, 0);
        chk("zero_busy_done", busy1, 0);
        chk("zero_vec_done", vec1, 31);
        @(negedge clk);
        chk("done_pulse", done1, 0);
        chk("idle_vec", vec1, 31);
        m1 = 1; exp1 = 32'hAAAAAAAB;
        sweep(1'b0, -1, n);
        chk("lsb_lat", n, 65);
        chk("lsb_mask", mask1, 32'hAAAAAAAA);
        chk("lsb_ones", ones1, 16);
        chk("lsb_mis", mis1, 1);
        repeat (5) @(negedge clk);
        chk("hold_mask", mask1, 32'hAAAAAAAA);
        chk("hold_ones", ones1, 16);
        chk("hold_mis", mis1, 1);
        m3 = 2; exp3 = 32'h80000000;
        sweep(1'b1, -1, n);
        chk("and_lat", n, 129);
        chk("and_mask", mask3, 32'h80000000);
        chk("and_ones", ones3, 1);
        chk("and_mis", mis3, 0);
        chk("and_runs", chg3, 31);
        chk("and_hold4", bad3, 0);
        exp1 = 32'hAAAAAAAA;
        sweep(1'b0, 10, n);
        chk("restart_lat", n, 65);
        chk("restart_mask", mask1, 32'hAAAAAAAA);
        chk("restart_mis", mis1, 0);
        nd = 0;
        repeat (80) begin
            @(negedge clk);
            if (done1) nd++;
        end
        chk("restart_extra_done", nd, 0);
        start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        n = 1;
        while (vec1 != 5'd20 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_v20", n, 41);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_vec", vec1, 0);
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_mask", mask1, 0);
        chk("mid_rst_ones", ones1, 0);
        @(negedge clk) rst_n = 1'b1;
        nd = 0;
        repeat (80) begin
            @(negedge clk);
            if (done1 || busy1) nd++;
        end
        chk("post_rst_quiet", nd, 0);
        rst_n = 1'b0;
        #2;
        @(negedge clk) rst_n = 1'b1;
        sweep(1'b0, -1, n);
        chk("fresh_lat", n, 65);
        chk("fresh_mask", mask1, 32'hAAAAAAAA);
        chk("fresh_ones", ones1, 16);
        m3 = 1; exp3 = 32'hAAAAAAAA;
        start3 = 1'b1;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (done3) break;
        end
        chk("b2b_first", n, 129);
        k = 0; low = 0;
        while (k < 400) begin
            @(negedge clk);
            k++;
            if (!busy3) low++;
            if (done3) break;
        end
        start3 = 1'b0;
        chk("b2b_gap", k, 130);
        chk("b2b_busy_low", low, 2);
        chk("b2b_mask", mask3, 32'hAAAAAAAA);
        chk("b2b_ones", ones3, 16);
        chk("b2b_mis", mis3, 0);
        chk("b2b_hold4", bad3, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
